// File: rtl/tile_harness_pkg.sv
// Shared state encoding and default widths for the tile harness controller.
package tile_harness_pkg;

  localparam int unsigned DEF_REG_WIDTH      = 32;
  localparam int unsigned DEF_CSR_IN_WIDTH   = 16;
  localparam int unsigned DEF_CSR_OUT_WIDTH  = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;
  localparam int unsigned CNT_WIDTH          = 16;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_ISSUE    = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT_RES = 2'd2;
  localparam logic [STATE_WIDTH-1:0] ST_RESP     = 2'd3;

endpackage

// File: rtl/tile_harness_sat_cnt.sv
// Status counter that sticks at all-ones instead of wrapping.
module tile_harness_sat_cnt
  import tile_harness_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Count up on inc, hold once saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tile_harness_ctrl.sv
// Command/response sequencer between a host and one compute tile.
module tile_harness_ctrl
  import tile_harness_pkg::*;
#(
  parameter int unsigned REG_WIDTH      = DEF_REG_WIDTH,
  parameter int unsigned CSR_IN_WIDTH   = DEF_CSR_IN_WIDTH,
  parameter int unsigned CSR_OUT_WIDTH  = DEF_CSR_OUT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CSR_IN_WIDTH-1:0]  cmd_csr,
  input  logic [REG_WIDTH-1:0]     cmd_a,
  input  logic [REG_WIDTH-1:0]     cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [CSR_OUT_WIDTH-1:0] rsp_csr,
  output logic [REG_WIDTH-1:0]     rsp_c,
  output logic                     rsp_timeout,
  output logic                     harness_en,
  output logic                     tile_en,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic                     csr_in_re,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  output logic [CNT_WIDTH-1:0]     ops_done,
  output logic [CNT_WIDTH-1:0]     timeouts
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STATE_WIDTH-1:0] state, next_state;
  logic [TMR_W-1:0]       tmr;
  logic                   have_res;

  logic load_cmd_c, clr_csr_in_c, cap_res_c, set_timeout_c, rsp_done_c, got_c, tmr_done_c;

  // Last cycle of the wait window: the response must be issued on this edge.
  assign tmr_done_c = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and datapath strobes; a result captured early in ISSUE still waits for csr_in_re.
  always_comb begin
    next_state    = state;
    load_cmd_c    = 1'b0;
    clr_csr_in_c  = 1'b0;
    cap_res_c     = 1'b0;
    set_timeout_c = 1'b0;
    rsp_done_c    = 1'b0;
    got_c         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load_cmd_c = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cap_res_c = csr_out_we;
        got_c     = csr_out_we || have_res;
        if (csr_in_re) clr_csr_in_c = 1'b1;
        if (csr_in_re && got_c) begin
          next_state = ST_RESP;
        end else if (tmr_done_c) begin
          next_state    = ST_RESP;
          clr_csr_in_c  = 1'b1;
          set_timeout_c = !got_c;
        end else if (csr_in_re) begin
          next_state = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (csr_out_we) begin
          cap_res_c  = 1'b1;
          next_state = ST_RESP;
        end else if (tmr_done_c) begin
          set_timeout_c = 1'b1;
          next_state    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done_c = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered outputs, tile drive, result capture and wait timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      harness_en  <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      tile_en     <= 1'b0;
      csr_in      <= '0;
      data_reg_a  <= '0;
      data_reg_b  <= '0;
      rsp_csr     <= '0;
      rsp_c       <= '0;
      rsp_timeout <= 1'b0;
      have_res    <= 1'b0;
      tmr         <= '0;
    end else begin
      harness_en <= 1'b1;
      cmd_ready  <= (next_state == ST_IDLE);
      rsp_valid  <= (next_state == ST_RESP);
      if (state == ST_ISSUE || state == ST_WAIT_RES) tmr <= tmr + 1'b1;
      if (load_cmd_c) begin
        csr_in     <= cmd_csr;
        data_reg_a <= cmd_a;
        data_reg_b <= cmd_b;
        tile_en    <= 1'b1;
        have_res   <= 1'b0;
        tmr        <= '0;
      end
      if (clr_csr_in_c) csr_in <= '0;
      if (cap_res_c) begin
        rsp_csr     <= csr_out;
        rsp_c       <= data_reg_c;
        rsp_timeout <= 1'b0;
        have_res    <= 1'b1;
      end
      if (set_timeout_c) begin
        rsp_csr     <= '0;
        rsp_c       <= '0;
        rsp_timeout <= 1'b1;
      end
      if (rsp_done_c) begin
        tile_en    <= 1'b0;
        data_reg_a <= '0;
        data_reg_b <= '0;
        have_res   <= 1'b0;
      end
    end
  end

  tile_harness_sat_cnt u_ops_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_done_c && !rsp_timeout),
    .count (ops_done)
  );

  tile_harness_sat_cnt u_to_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_done_c && rsp_timeout),
    .count (timeouts)
  );

endmodule

// File: tb/tb_tile_harness_ctrl.sv
// Randomized transaction-level bench for tile_harness_ctrl.
module tb_tile_harness_ctrl;

  localparam int unsigned RW = 32;
  localparam int unsigned CIW = 16;
  localparam int unsigned COW = 16;
  localparam int T = 24;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
  logic [CIW-1:0] cmd_csr, csr_in;
  logic [RW-1:0]  cmd_a, cmd_b, rsp_c, data_reg_a, data_reg_b, data_reg_c;
  logic [COW-1:0] rsp_csr, csr_out;
  logic harness_en, tile_en, csr_in_re, csr_out_we;
  logic [15:0] ops_done, timeouts;

  int n_tests = 0;
  int n_fail  = 0;
  int ops_m   = 0;
  int tos_m   = 0;

  always #5 clk = ~clk;

  tile_harness_ctrl #(
    .REG_WIDTH(RW), .CSR_IN_WIDTH(CIW), .CSR_OUT_WIDTH(COW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_csr(cmd_csr), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_csr(rsp_csr), .rsp_c(rsp_c), .rsp_timeout(rsp_timeout),
    .harness_en(harness_en), .tile_en(tile_en), .csr_in(csr_in),
    .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .csr_in_re(csr_in_re), .csr_out(csr_out), .csr_out_we(csr_out_we),
    .data_reg_c(data_reg_c),
    .ops_done(ops_done), .timeouts(timeouts)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One transaction: tile pulses re at cycle r and we at cycle w (-1 = never),
  // host holds off rsp_ready for hold cycles; rst_at >= 0 aborts with reset.
  task automatic run_op(input logic [15:0] csr, input logic [31:0] a, input logic [31:0] b,
                        input int r, input int w, input logic [15:0] w_csr,
                        input logic [31:0] w_c, input int hold, input int rst_at);
    bit got, seen;
    int k_resp, wt;
    logic [15:0] exp_csr;
    logic [31:0] exp_c;
    got     = (w >= 0) && (w < T);
    k_resp  = got ? (((r > w) ? r : w) + 1) : T;
    exp_csr = got ? w_csr : 16'h0;
    exp_c   = got ? w_c : 32'h0;
    wt = 0;
    while (!cmd_ready && wt < 50) begin @(negedge clk); wt++; end
    check_eq("cmd_ready_pre", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_csr = csr; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_csr = 16'($urandom); cmd_a = $urandom; cmd_b = $urandom;
    seen = 1'b0;
    for (int kk = 0; kk <= T + 4 && !seen; kk++) begin
      if (kk == rst_at) begin
        rst = 1'b1; csr_in_re = 1'b0; csr_out_we = 1'b0;
        @(negedge clk);
        check_eq("rst_tile_en", 64'(tile_en), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_harness_en", 64'(harness_en), 64'd0);
        check_eq("rst_csr_in", 64'(csr_in), 64'd0);
        check_eq("rst_data_a", 64'(data_reg_a), 64'd0);
        check_eq("rst_ops", 64'(ops_done), 64'd0);
        check_eq("rst_tos", 64'(timeouts), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_harness_en", 64'(harness_en), 64'd1);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        ops_m = 0; tos_m = 0;
        return;
      end
      if (rsp_valid) begin
        seen = 1'b1;
        check_eq("rsp_latency", 64'(kk), 64'(k_resp));
      end else begin
        if (kk == 0) begin
          check_eq("issue_tile_en", 64'(tile_en), 64'd1);
          check_eq("issue_cmd_ready", 64'(cmd_ready), 64'd0);
          check_eq("issue_data_a", 64'(data_reg_a), 64'(a));
          check_eq("issue_data_b", 64'(data_reg_b), 64'(b));
        end
        check_eq("csr_in", 64'(csr_in), (kk <= r) ? 64'(csr) : 64'd0);
        csr_in_re  = (kk == r);
        csr_out_we = (kk == w);
        csr_out    = (kk == w) ? w_csr : 16'($urandom);
        data_reg_c = (kk == w) ? w_c : $urandom;
        @(negedge clk);
      end
    end
    csr_in_re = 1'b0; csr_out_we = 1'b0;
    if (!seen) check_eq("rsp_seen", 64'd0, 64'd1);
    check_eq("rsp_csr", 64'(rsp_csr), 64'(exp_csr));
    check_eq("rsp_c", 64'(rsp_c), 64'(exp_c));
    check_eq("rsp_timeout", 64'(rsp_timeout), 64'(!got));
    check_eq("resp_csr_in", 64'(csr_in), 64'd0);
    check_eq("resp_data_a", 64'(data_reg_a), 64'(a));
    for (int h = 0; h < hold; h++) begin
      csr_out_we = 1'($urandom); csr_in_re = 1'($urandom);
      csr_out = 16'($urandom); data_reg_c = $urandom;
      @(negedge clk);
      check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_rsp_csr", 64'(rsp_csr), 64'(exp_csr));
      check_eq("bp_rsp_c", 64'(rsp_c), 64'(exp_c));
      check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check_eq("bp_tile_en", 64'(tile_en), 64'd1);
    end
    csr_in_re = 1'b0; csr_out_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (got) ops_m = (ops_m >= 65535) ? 65535 : ops_m + 1;
    else     tos_m = (tos_m >= 65535) ? 65535 : tos_m + 1;
    check_eq("done_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("done_tile_en", 64'(tile_en), 64'd0);
    check_eq("done_data_a", 64'(data_reg_a), 64'd0);
    check_eq("done_data_b", 64'(data_reg_b), 64'd0);
    check_eq("done_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("ops_done", 64'(ops_done), 64'(ops_m));
    check_eq("timeouts", 64'(timeouts), 64'(tos_m));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_csr = '0; cmd_a = '0; cmd_b = '0;
    csr_in_re = 1'b0; csr_out_we = 1'b0; csr_out = '0; data_reg_c = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check_eq("reset_harness_en", 64'(harness_en), 64'd0);
    check_eq("reset_tile_en", 64'(tile_en), 64'd0);
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_csr_in", 64'(csr_in), 64'd0);
    check_eq("reset_ops", 64'(ops_done), 64'd0);
    check_eq("reset_tos", 64'(timeouts), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_harness_en", 64'(harness_en), 64'd1);
    check_eq("first_cmd_ready", 64'(cmd_ready), 64'd1);

    // basic op
    run_op(16'h0001, 32'h5, 32'h3, 2, 3, 16'h8000, 32'h8, 0, -1);
    check_eq("basic_ops_done", 64'(ops_done), 64'd1);
    // timeout
    run_op(16'h00A5, $urandom, $urandom, 1, -1, 16'h0, 32'h0, 0, -1);
    check_eq("timeout_count", 64'(timeouts), 64'd1);
    // simultaneous re/we in first ISSUE cycle
    run_op(16'h1234, $urandom, $urandom, 0, 0, 16'hBEEF, 32'hCAFE_F00D, 0, -1);
    // backpressure
    run_op(16'h0F0F, $urandom, $urandom, 1, 2, 16'h4321, 32'h1357_9BDF, 10, -1);
    // result before csr_in_re
    run_op(16'h7777, $urandom, $urandom, 4, 1, 16'h0042, 32'hDEAD_BEEF, 1, -1);
    // reset while waiting for result, then a normal op
    run_op(16'h2222, $urandom, $urandom, 1, -1, 16'h0, 32'h0, 0, 5);
    run_op(16'h3333, $urandom, $urandom, 2, 4, 16'h0099, 32'h0000_0ABC, 0, -1);

    for (int i = 0; i < 30; i++) begin
      int r, w, sel;
      r   = $urandom_range(0, T - 1);
      sel = $urandom_range(0, 3);
      w   = (sel == 0) ? -1 : $urandom_range(0, T + 3);
      run_op(16'($urandom), $urandom, $urandom, r, w, 16'($urandom), $urandom,
             $urandom_range(0, 4), -1);
    end

    // saturation of the completion counter
    force dut.u_ops_cnt.count = 16'hFFFE;
    @(negedge clk);
    release dut.u_ops_cnt.count;
    ops_m = 65534;
    for (int i = 0; i < 3; i++)
      run_op(16'($urandom), $urandom, $urandom, 0, 1, 16'($urandom), $urandom, 0, -1);
    check_eq("sat_ops_done", 64'(ops_done), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
